// File: rtl/rca_seg_display.sv
// rtl/rca_seg_display.sv - adder result to BCD (double-dabble) on a 3-digit muxed 7-segment display
// Optional: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module rca_seg_display #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic             co,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             done,
  output logic [6:0]       seg,
  output logic [2:0]       an
);

  localparam int BW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);
  localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t          state;
  logic [BW-1:0]   bin;
  logic [11:0]     bcd;
  logic [11:0]     bcd_adj;
  logic [11:0]     disp;
  logic [CW-1:0]   iter;
  logic [PW-1:0]   presc;
  logic [1:0]      digit;

  function automatic logic [11:0] dabble_adj(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb bcd_adj = dabble_adj(bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      done     <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      disp     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin      <= {co, s};
            bcd      <= '0;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
          iter       <= iter + CW'(1);
          if (iter == LAST_ITER) state <= LOAD;
        end
        LOAD: begin
          // display register only changes here, so conversion never shows partial values
          disp     <= bcd;
          done     <= 1'b1;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // free-running scan, independent of the conversion FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      digit <= '0;
    end else if (presc == LAST_PRESC) begin
      presc <= '0;
      digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    logic [3:0] nib;
    logic       blank;
    nib   = 4'd0;
    blank = 1'b0;
    an    = 3'b111;
    case (digit)
      2'd0: begin
        an  = 3'b110;
        nib = disp[3:0];
      end
      2'd1: begin
        an  = 3'b101;
        nib = disp[7:4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank = (disp[11:4] == 8'd0);
`else
        blank = 1'b0;
`endif
      end
      2'd2: begin
        an  = 3'b011;
        nib = disp[11:8];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank = (disp[11:8] == 4'd0);
`else
        blank = 1'b0;
`endif
      end
      default: blank = 1'b1;
    endcase
    seg = blank ? 7'b1111111 : seg_of(nib);
  end

endmodule

// File: tb/tb_rca_seg_display.sv
// tb/tb_rca_seg_display.sv - scoreboard bench for rca_seg_display
module tb_rca_seg_display;
  localparam int WIDTH    = 8;
  localparam int SCAN_DIV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             in_valid;
  logic             in_ready;
  logic             done;
  logic [6:0]       seg;
  logic [2:0]       an;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] shown;

  rca_seg_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .s(s), .co(co), .in_valid(in_valid),
    .in_ready(in_ready), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx);
    logic [3:0] n;
    n = b[4*idx +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (idx == 2 && b[11:8] == 4'd0) return 7'b1111111;
    if (idx == 1 && b[11:4] == 8'd0) return 7'b1111111;
`endif
    return seg_code(n);
  endfunction

  function automatic logic [2:0] scan_exp(input int i);
    case ((i / SCAN_DIV) % 3)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_seg(input string tag, input logic [11:0] b);
    int idx;
    case (an)
      3'b110:  idx = 0;
      3'b101:  idx = 1;
      3'b011:  idx = 2;
      default: idx = -1;
    endcase
    if (idx < 0) check_eq({tag, "_an"}, 32'(an), 32'(3'b110));
    else         check_eq(tag, 32'(seg), 32'(exp_seg(b, idx)));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic send(input int v);
    int t;
    t = 0;
    while (!in_ready && t < 40) begin
      step();
      t++;
    end
    if (t == 40) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    s        = v[7:0];
    co       = v[8];
    in_valid = 1'b1;
    exp_q.push_back(to_bcd(v));
    step();
    in_valid = 1'b0;
    check_eq("ready_fall", 32'(in_ready), 32'd0);
  endtask

  task automatic run_until_done(input int start, input string tag);
    int cnt;
    cnt = start;
    while (cnt < 40) begin
      step();
      cnt++;
      if (done) break;
      sample_seg({tag, "_hold"}, shown);
      check_eq({tag, "_busy"}, 32'(in_ready), 32'd0);
    end
    check_eq({tag, "_latency"}, 32'(cnt), 32'(WIDTH + 2));
    if (done) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_spurious_done"}, 32'(done), 32'd0);
      end else begin
        shown = exp_q.pop_front();
        sample_seg({tag, "_new"}, shown);
      end
    end
  endtask

  task automatic check_display(input string tag);
    repeat (3 * SCAN_DIV) begin
      step();
      sample_seg(tag, shown);
      check_eq({tag, "_nodone"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    s        = '0;
    co       = 1'b0;
    shown    = 12'h000;
    do_reset(2);

    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_seg", 32'(seg), 32'(7'b1000000));
    for (int i = 0; i < 13; i++) begin
      check_eq("scan_an", 32'(an), 32'(scan_exp(i)));
      sample_seg("rst_disp", shown);
      step();
    end

    send(123);
    run_until_done(0, "v123");
    check_display("v123_disp");

    send(9'h1FF);
    run_until_done(0, "v511");
    check_display("v511_disp");

    send(9'h12C);
    run_until_done(0, "v300");
    check_display("v300_disp");

    send(200);
    repeat (3) begin
      step();
      sample_seg("busy_hold", shown);
      check_eq("busy_ready0", 32'(in_ready), 32'd0);
    end
    s        = 8'd45;
    co       = 1'b0;
    in_valid = 1'b1;
    run_until_done(3, "busy200");
    check_eq("busy_ready1", 32'(in_ready), 32'd1);
    exp_q.push_back(to_bcd(45));
    step();
    in_valid = 1'b0;
    check_eq("busy_capture", 32'(in_ready), 32'd0);
    run_until_done(0, "busy45");
    check_display("v045_disp");

    send(7);
    run_until_done(0, "v007");
    check_display("v007_disp");

    send(99);
    repeat (5) begin
      step();
      sample_seg("mid_hold", shown);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_ready", 32'(in_ready), 32'd1);
    check_eq("mid_done", 32'(done), 32'd0);
    check_eq("mid_an", 32'(an), 32'(3'b110));
    exp_q.delete();
    shown = 12'h000;
    check_display("mid_disp");

    send(58);
    run_until_done(0, "v058");
    check_display("v058_disp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
